// File: rtl/store_lane_unit.sv
// -----------------------------------------------------------------------------
// store_lane_unit
//
// Store byte-lane unit between the MEM stage and the data-memory/bridge bus.
// Takes one store request (size, address, right-justified data), builds the
// lane-aligned write data and byte enables for a DW-bit bus, and presents them
// as one or two registered bus beats. A misaligned store either splits into
// two aligned beats (SPLIT_MISALIGN=1) or is rejected with a one-cycle
// exc_ades pulse (SPLIT_MISALIGN=0). An illegal size (wider than the bus) is
// always rejected.
//
// Handshake semantics (both the req_* and bus_* sides): a transfer happens on
// a rising clk edge where valid && ready are both high. A valid, once raised,
// stays high with its payload stable until that transfer (reset excepted).
// req_ready here depends only on state, never on req_valid.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   req_valid  store request present        req_ready  unit idle, can accept
//   req_size   log2 of bytes (0..3)          req_addr   byte address
//   req_wdata  store data, right-justified
//   bus_valid  beat present                  bus_ready  bus accepts beat
//   bus_addr   NB-aligned beat address       bus_be     byte enables
//   bus_wdata  lane-aligned write data
//   exc_ades   one-cycle pulse: request rejected
//   done       one-cycle pulse: last beat of a store accepted
//   dbg_state  current FSM state (0 IDLE, 1 BEAT0, 2 BEAT1)
// -----------------------------------------------------------------------------
module store_lane_unit #(
  parameter int DW             = 32,
  parameter bit SPLIT_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [DW-1:0]     req_wdata,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [31:0]       bus_addr,
  output logic [DW/8-1:0]   bus_be,
  output logic [DW-1:0]     bus_wdata,
  output logic              exc_ades,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t state, state_nx;

  // Second beat, latched at accept and moved onto the bus after beat 0.
  logic              pend;
  logic [31:0]       addr2;
  logic [NB-1:0]     be2;
  logic [DW-1:0]     wdata2;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [OW-1:0]     off;
  logic [3:0]        s_bytes;
  logic [3:0]        s_m1;
  logic              illegal;
  logic              misaligned;
  logic              reject;
  logic              accept;
  logic              hs;
  logic [31:0]       base_addr;
  logic [2*NB-1:0]   mask;
  logic [DW-1:0]     wd_keep;
  logic [2*DW-1:0]   data_sh;

  assign off        = req_addr[OW-1:0];
  assign s_bytes    = 4'd1 << req_size;
  assign s_m1       = s_bytes - 4'd1;
  assign illegal    = (32'(s_bytes) > NB);
  assign misaligned = ((32'(s_m1) & 32'(off)) != 32'd0);
  assign reject     = illegal || (misaligned && !SPLIT_MISALIGN);
  assign accept     = req_valid && req_ready;
  assign hs         = bus_valid && bus_ready;
  assign base_addr  = {req_addr[31:OW], {OW{1'b0}}};

  // Mask spans two bus words so a store crossing the NB boundary lands its
  // upper bytes in the high half, which becomes the second beat.
  always_comb begin
    mask    = '0;
    wd_keep = '0;
    for (int i = 0; i < 2*NB; i++) begin
      mask[i] = (i >= int'(off)) && (i < int'(off) + int'(s_bytes));
    end
    for (int b = 0; b < NB; b++) begin
      if (b < int'(s_bytes)) wd_keep[8*b +: 8] = req_wdata[8*b +: 8];
    end
    data_sh = {{DW{1'b0}}, wd_keep} << {off, 3'b000};
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !reject) state_nx = BEAT0;
      BEAT0:   if (hs) state_nx = pend ? BEAT1 : IDLE;
      BEAT1:   if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (state == IDLE);
    bus_valid = (state == BEAT0) || (state == BEAT1);
    dbg_state = state;
  end

  // ---------------------------------------------------------------------------
  // Registered bus payload and pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      pend      <= 1'b0;
      addr2     <= '0;
      be2       <= '0;
      wdata2    <= '0;
      exc_ades  <= 1'b0;
      done      <= 1'b0;
    end else begin
      exc_ades <= accept && reject;
      done     <= hs && ((state == BEAT1) || ((state == BEAT0) && !pend));
      if (accept && !reject) begin
        bus_addr  <= base_addr;
        bus_be    <= mask[NB-1:0];
        bus_wdata <= data_sh[DW-1:0];
        pend      <= |mask[2*NB-1:NB];
        addr2     <= base_addr + 32'(NB);   // wraps mod 2^32
        be2       <= mask[2*NB-1:NB];
        wdata2    <= data_sh[2*DW-1:DW];
      end else if (hs && (state == BEAT0) && pend) begin
        bus_addr  <= addr2;
        bus_be    <= be2;
        bus_wdata <= wdata2;
        pend      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_store_lane_unit.sv
// -----------------------------------------------------------------------------
// tb_store_lane_unit
//
// Three configurations side by side: DW=32 split, DW=32 reject, DW=64 split.
// One stimulus process drives the shared request/bus inputs; 'sel' routes
// valid/ready to one unit at a time and muxes that unit's outputs for
// checking. Expected beats come from a byte-by-byte placement model.
// -----------------------------------------------------------------------------
module tb_store_lane_unit;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic [2:0] rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stimulus signals and DUT wiring
  // ---------------------------------------------------------------------------
  int          sel;
  logic        req_valid;
  logic        bus_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;

  logic [2:0]  rv, br;
  assign rv = {req_valid && (sel == 2), req_valid && (sel == 1), req_valid && (sel == 0)};
  assign br = {bus_ready && (sel == 2), bus_ready && (sel == 1), bus_ready && (sel == 0)};

  logic        rr0, rr1, rr2, bv0, bv1, bv2, ex0, ex1, ex2, dn0, dn1, dn2;
  logic [31:0] ba0, ba1, ba2;
  logic [3:0]  be0, be1;
  logic [7:0]  be2;
  logic [31:0] wd0, wd1;
  logic [63:0] wd2;
  logic [1:0]  st0, st1, st2;

  store_lane_unit #(.DW(32), .SPLIT_MISALIGN(1'b1)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .req_valid(rv[0]), .req_ready(rr0),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .bus_valid(bv0), .bus_ready(br[0]), .bus_addr(ba0), .bus_be(be0),
    .bus_wdata(wd0), .exc_ades(ex0), .done(dn0), .dbg_state(st0));

  store_lane_unit #(.DW(32), .SPLIT_MISALIGN(1'b0)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .req_valid(rv[1]), .req_ready(rr1),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .bus_valid(bv1), .bus_ready(br[1]), .bus_addr(ba1), .bus_be(be1),
    .bus_wdata(wd1), .exc_ades(ex1), .done(dn1), .dbg_state(st1));

  store_lane_unit #(.DW(64), .SPLIT_MISALIGN(1'b1)) u_dut2 (
    .clk(clk), .reset(rst_n[2]), .req_valid(rv[2]), .req_ready(rr2),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_valid(bv2), .bus_ready(br[2]), .bus_addr(ba2), .bus_be(be2),
    .bus_wdata(wd2), .exc_ades(ex2), .done(dn2), .dbg_state(st2));

  // Observed outputs of the selected unit
  logic        o_rr, o_bv, o_ex, o_dn;
  logic [31:0] o_ba;
  logic [7:0]  o_be;
  logic [63:0] o_wd;
  logic [1:0]  o_st;

  always_comb begin
    case (sel)
      1: begin
        o_rr = rr1; o_bv = bv1; o_ex = ex1; o_dn = dn1; o_ba = ba1;
        o_be = {4'b0, be1}; o_wd = {32'b0, wd1}; o_st = st1;
      end
      2: begin
        o_rr = rr2; o_bv = bv2; o_ex = ex2; o_dn = dn2; o_ba = ba2;
        o_be = be2; o_wd = wd2; o_st = st2;
      end
      default: begin
        o_rr = rr0; o_bv = bv0; o_ex = ex0; o_dn = dn0; o_ba = ba0;
        o_be = {4'b0, be0}; o_wd = {32'b0, wd0}; o_st = st0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cfg=%0d got=%h exp=%h", tag, sel, got, exp);
    end
  endtask

  // Reference model: place each stored byte at its byte address and see
  // which bus word (beat) and lane it falls in.
  bit          exp_exc;
  int          exp_nbeats;
  logic [31:0] exp_addr [2];
  logic [7:0]  exp_be   [2];
  logic [63:0] exp_data [2];

  task automatic model(input int c, input logic [1:0] size,
                       input logic [31:0] addr, input logic [63:0] data);
    int nb, s, off, pos;
    bit split;
    nb    = (c == 2) ? 8 : 4;
    split = (c != 1);
    s     = 1 << size;
    off   = int'(addr[3:0]) % nb;
    exp_exc = (s > nb) || (!split && (off % s) != 0);
    for (int j = 0; j < 2; j++) begin
      exp_be[j]   = '0;
      exp_data[j] = '0;
    end
    if (!exp_exc) begin
      for (int k = 0; k < s; k++) begin
        pos = off + k;
        exp_be[pos / nb][pos % nb]             = 1'b1;
        exp_data[pos / nb][8*(pos % nb) +: 8]  = data[8*k +: 8];
      end
    end
    exp_nbeats  = (off + s > nb) ? 2 : 1;
    exp_addr[0] = addr - 32'(off);
    exp_addr[1] = exp_addr[0] + 32'(nb);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one store on unit c, called at a negedge-aligned time. force_stall
  // holds bus_ready low for that many cycles on each beat before random ready.
  // ---------------------------------------------------------------------------
  task automatic do_store(input int c, input logic [1:0] size, input logic [31:0] addr,
                          input logic [63:0] data, input int force_stall);
    int  stalls;
    bit  r;
    sel       = c;
    req_size  = size;
    req_addr  = addr;
    req_wdata = data;
    req_valid = 1'b1;
    bus_ready = 1'b0;
    model(c, size, addr, data);
    #1;
    chk("req_ready_idle", 64'(o_rr), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    if (exp_exc) begin
      chk("exc_pulse", 64'(o_ex), 64'd1);
      chk("exc_no_valid", 64'(o_bv), 64'd0);
      chk("exc_no_done", 64'(o_dn), 64'd0);
      chk("exc_ready", 64'(o_rr), 64'd1);
      return;
    end
    for (int j = 0; j < exp_nbeats; j++) begin
      stalls = 0;
      forever begin
        chk("bus_valid", 64'(o_bv), 64'd1);
        chk("bus_addr", 64'(o_ba), 64'(exp_addr[j]));
        chk("bus_be", 64'(o_be), 64'(exp_be[j]));
        chk("bus_wdata", o_wd, exp_data[j]);
        chk("busy_ready", 64'(o_rr), 64'd0);
        chk("busy_exc", 64'(o_ex), 64'd0);
        chk("busy_done", 64'(o_dn), 64'd0);
        if (stalls < force_stall)          r = 1'b0;
        else if (stalls >= force_stall + 4) r = 1'b1;
        else                                r = ($urandom_range(0, 2) != 0);
        bus_ready = r;
        @(posedge clk);
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        if (r) break;
        stalls++;
      end
    end
    chk("done_pulse", 64'(o_dn), 64'd1);
    chk("done_idle", 64'(o_bv), 64'd0);
    chk("done_ready", 64'(o_rr), 64'd1);
    chk("done_no_exc", 64'(o_ex), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  logic [31:0] regions [4];

  initial begin
    regions[0] = 32'h0000_1000;
    regions[1] = 32'h0000_2000;
    regions[2] = 32'hFFFF_FFF0;
    regions[3] = 32'h8000_0000;

    sel = 0; req_valid = 1'b0; bus_ready = 1'b0;
    req_size = '0; req_addr = '0; req_wdata = '0;
    rst_n = 3'b000;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      sel = c;
      #1;
      chk("rst_bus_valid", 64'(o_bv), 64'd0);
      chk("rst_bus_addr", 64'(o_ba), 64'd0);
      chk("rst_bus_be", 64'(o_be), 64'd0);
      chk("rst_bus_wdata", o_wd, 64'd0);
      chk("rst_exc", 64'(o_ex), 64'd0);
      chk("rst_done", 64'(o_dn), 64'd0);
      chk("rst_state", 64'(o_st), 64'd0);
    end
    @(negedge clk);
    rst_n = 3'b111;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      sel = c;
      #1;
      chk("post_rst_ready", 64'(o_rr), 64'd1);
    end
    @(negedge clk);

    // Directed cases
    do_store(0, 2'd2, 32'h0000_1000, 64'hAABBCCDD, 0);  // sw aligned
    do_store(0, 2'd0, 32'h0000_1003, 64'h123456EE, 0);  // sb lane 3
    do_store(0, 2'd1, 32'h0000_1002, 64'hFFFF1234, 0);  // sh lanes 2-3
    do_store(0, 2'd2, 32'h0000_1003, 64'h11223344, 0);  // sw split
    do_store(1, 2'd2, 32'h0000_1003, 64'h11223344, 0);  // sw rejected
    do_store(1, 2'd1, 32'h0000_1001, 64'h00005566, 0);  // sh misaligned, rejected
    do_store(0, 2'd1, 32'h0000_1001, 64'h00005566, 0);  // sh within word, one beat
    do_store(2, 2'd2, 32'h0000_200C, 64'hDEADBEEF, 0);  // DW=64 upper half
    do_store(0, 2'd3, 32'h0000_1000, 64'h0102030405060708, 0); // illegal size
    do_store(2, 2'd3, 32'h0000_2005, 64'h0102030405060708, 0); // dword split
    do_store(0, 2'd2, 32'hFFFF_FFFE, 64'hCAFEF00D, 0);  // second beat wraps
    do_store(0, 2'd2, 32'h0000_1000, 64'h55AA55AA, 3);  // backpressure
    do_store(0, 2'd2, 32'h0000_1002, 64'h99887766, 2);  // backpressure on split

    // Randomized stores across configurations
    for (int n = 0; n < 300; n++) begin
      do_store($urandom_range(0, 2), 2'($urandom_range(0, 3)),
               regions[$urandom_range(0, 3)] + 32'($urandom_range(0, 15)),
               {$urandom, $urandom}, ($urandom_range(0, 7) == 0) ? 2 : 0);
    end

    // Reset while the second beat of a split store is on the bus
    @(negedge clk);
    sel = 0; req_size = 2'd2; req_addr = 32'h0000_1003; req_wdata = 64'h11223344;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    bus_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    chk("beat1_valid", 64'(o_bv), 64'd1);
    chk("beat1_addr", 64'(o_ba), 64'h1004);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("async_rst_valid", 64'(o_bv), 64'd0);
    chk("async_rst_be", 64'(o_be), 64'd0);
    chk("async_rst_done", 64'(o_dn), 64'd0);
    @(negedge clk);
    #1;
    chk("rst_hold_done", 64'(o_dn), 64'd0);
    rst_n[0] = 1'b1;
    @(negedge clk);
    #1;
    chk("after_rst_done", 64'(o_dn), 64'd0);
    chk("after_rst_ready", 64'(o_rr), 64'd1);
    @(negedge clk);
    do_store(0, 2'd0, 32'h0000_1001, 64'h000000A5, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the sequence is bounded, so expiring here means a lockup.
  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

endmodule
